// File: rtl/intersection_scheduler.sv
// Two-road intersection phase sequencer, all timing counted in tick strobes.
// Optional pedestrian walk phase is compiled in with `define PED_WALK_EN.
module intersection_scheduler #(
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 3,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       req_b,
  input  logic       bt,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       walk,
  output logic [2:0] phase,
  output logic       bt_pending
);
  localparam int TMAX = (1 << CW) - 1;

  if (T_GREEN_MIN < 1 || T_GREEN_MIN > TMAX || T_GREEN_MAX < 1 || T_GREEN_MAX > TMAX ||
      T_YELLOW < 1 || T_YELLOW > TMAX || T_ALLRED < 1 || T_ALLRED > TMAX ||
      T_WALK < 1 || T_WALK > TMAX) begin : g_bad_timing
    $error("intersection_scheduler: timing parameter out of range for CW");
  end

  localparam logic [2:0] S_A_GRN  = 3'd0;
  localparam logic [2:0] S_A_YEL  = 3'd1;
  localparam logic [2:0] S_RED_AB = 3'd2;
  localparam logic [2:0] S_B_GRN  = 3'd3;
  localparam logic [2:0] S_B_YEL  = 3'd4;
  localparam logic [2:0] S_RED_BA = 3'd5;
`ifdef PED_WALK_EN
  localparam logic [2:0] S_WALK   = 3'd6;
  localparam logic [CW:0] E_WALK  = (CW+1)'(T_WALK);
`endif

  localparam logic [CW:0] E_GMIN = (CW+1)'(T_GREEN_MIN);
  localparam logic [CW:0] E_GMAX = (CW+1)'(T_GREEN_MAX);
  localparam logic [CW:0] E_YEL  = (CW+1)'(T_YELLOW);
  localparam logic [CW:0] E_AR   = (CW+1)'(T_ALLRED);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bt_pending_q, bt_pending_d;
  logic [2:0]    a_q, a_d, b_q, b_d;
  logic          walk_q, walk_d;
  logic [CW:0]   e;
  logic          req_eff, ped_go, enter;

  always_comb begin
    e = {1'b0, cnt_q} + (CW+1)'(1);
`ifdef PED_WALK_EN
    req_eff = req_b;
    ped_go  = bt_pending_q;
`else
    // a latched button press keeps road B green like a parked vehicle would
    req_eff = req_b | bt_pending_q;
    ped_go  = 1'b0;
`endif
    state_d = state_q;
    case (state_q)
      S_A_GRN:  if (tick && e >= E_GMIN && (req_b || bt_pending_q)) state_d = S_A_YEL;
      S_A_YEL:  if (tick && e == E_YEL) state_d = S_RED_AB;
`ifdef PED_WALK_EN
      S_RED_AB: if (tick && e == E_AR) state_d = ped_go ? S_WALK : S_B_GRN;
      S_RED_BA: if (tick && e == E_AR) state_d = ped_go ? S_WALK : S_A_GRN;
      S_WALK:   if (tick && e == E_WALK) state_d = req_b ? S_B_GRN : S_A_GRN;
`else
      S_RED_AB: if (tick && e == E_AR) state_d = S_B_GRN;
      S_RED_BA: if (tick && e == E_AR) state_d = S_A_GRN;
`endif
      S_B_GRN:  if (tick && e >= E_GMIN && (!req_eff || e >= E_GMAX)) state_d = S_B_YEL;
      S_B_YEL:  if (tick && e == E_YEL) state_d = S_RED_BA;
      default:  state_d = S_A_GRN;  // illegal code recovers without waiting for tick
    endcase

    enter = (state_d != state_q);
    if (enter)                         cnt_d = '0;
    else if (tick && cnt_q != CW'(TMAX)) cnt_d = cnt_q + CW'(1);
    else                               cnt_d = cnt_q;

    bt_pending_d = bt_pending_q | bt;
`ifdef PED_WALK_EN
    if (enter && state_d == S_WALK) bt_pending_d = 1'b0;
`else
    if (enter && state_d == S_B_GRN) bt_pending_d = 1'b0;
`endif

    // lights decode the next state so outputs move on the transition edge
    a_d    = 3'b100;
    b_d    = 3'b100;
    walk_d = 1'b0;
    case (state_d)
      S_A_GRN: a_d = 3'b001;
      S_A_YEL: a_d = 3'b010;
      S_B_GRN: b_d = 3'b001;
      S_B_YEL: b_d = 3'b010;
`ifdef PED_WALK_EN
      S_WALK:  walk_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_A_GRN;
      cnt_q        <= '0;
      bt_pending_q <= 1'b0;
      a_q          <= 3'b001;
      b_q          <= 3'b100;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bt_pending_q <= bt_pending_d;
      a_q          <= a_d;
      b_q          <= b_d;
      walk_q       <= walk_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign walk       = walk_q;
  assign phase      = state_q;
  assign bt_pending = bt_pending_q;
endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler; expectations queued per step and
// popped after the clock edge. Build with +define+PED_WALK_EN for the walk variant.
module tb_intersection_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, req_b = 1'b0, bt = 1'b0;
  logic [2:0] A, B, phase;
  logic       walk, bt_pending;

  intersection_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req_b(req_b), .bt(bt),
    .A(A), .B(B), .walk(walk), .phase(phase), .bt_pending(bt_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic [2:0] a;
    logic [2:0] b;
    logic       w;
    logic       bp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic exp_t mk(logic [2:0] ph, logic bp);
    exp_t x;
    x.ph = ph; x.bp = bp; x.a = 3'b100; x.b = 3'b100; x.w = 1'b0;
    case (ph)
      3'd0: x.a = 3'b001;
      3'd1: x.a = 3'b010;
      3'd3: x.b = 3'b001;
      3'd4: x.b = 3'b010;
      3'd6: x.w = 1'b1;
      default: ;
    endcase
    return x;
  endfunction

  // expected phase k ticks after reset with req_b held high
  function automatic logic [2:0] reqb_phase(int k);
    if (k <= 3)  return 3'd0;
    if (k <= 5)  return 3'd1;
    if (k == 6)  return 3'd2;
    if (k <= 16) return 3'd3;
    if (k <= 18) return 3'd4;
    if (k == 19) return 3'd5;
    return 3'd0;
  endfunction

  task automatic check_out(string tag);
    exp_t x;
    total++;
    assert (sb.size() > 0) else begin
      bad++; $error("FAIL %s scoreboard: got empty want entry", tag);
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      assert (phase === x.ph) else begin
        bad++; $error("FAIL %s phase: got %0d want %0d", tag, phase, x.ph);
      end
      total++;
      assert (A === x.a) else begin
        bad++; $error("FAIL %s A: got %b want %b", tag, A, x.a);
      end
      total++;
      assert (B === x.b) else begin
        bad++; $error("FAIL %s B: got %b want %b", tag, B, x.b);
      end
      total++;
      assert (walk === x.w) else begin
        bad++; $error("FAIL %s walk: got %b want %b", tag, walk, x.w);
      end
      total++;
      assert (bt_pending === x.bp) else begin
        bad++; $error("FAIL %s bt_pending: got %b want %b", tag, bt_pending, x.bp);
      end
    end
  endtask

  task automatic step(string tag, logic t, logic r, logic p, logic [2:0] ph, logic bp);
    tick = t; req_b = r; bt = p;
    sb.push_back(mk(ph, bp));
    @(posedge clk); #1;
    check_out(tag);
  endtask

  // reset is dropped between edges and checked before any edge arrives
  task automatic do_reset(string tag);
    #2;
    rst_n = 1'b0; tick = 1'b0; req_b = 1'b0; bt = 1'b0;
    #1;
    sb.push_back(mk(3'd0, 1'b0));
    check_out(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset("rst_init");

    // idle: road A rests green
    for (int k = 1; k <= 30; k++) step($sformatf("idle_%0d", k), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // vehicle on road B: full cycle to B_GRN max and back
    do_reset("rst_t2");
    for (int k = 1; k <= 20; k++) step($sformatf("reqb_%0d", k), 1'b1, 1'b1, 1'b0, reqb_phase(k), 1'b0);

`ifdef PED_WALK_EN
    do_reset("rst_t3");
    step("ped_1", 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    step("ped_2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step("ped_3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step("ped_4", 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
    step("ped_5", 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
    step("ped_6", 1'b1, 1'b0, 1'b0, 3'd2, 1'b1);
    step("ped_7", 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);  // clear wins over simultaneous press
    step("ped_8", 1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
    step("ped_9", 1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
    step("ped_10", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
`else
    do_reset("rst_t4");
    step("btb_1", 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    step("btb_2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step("btb_3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step("btb_4", 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
    step("btb_5", 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
    step("btb_6", 1'b1, 1'b0, 1'b0, 3'd2, 1'b1);
    for (int k = 7; k <= 10; k++) step($sformatf("btb_%0d", k), 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    step("btb_11", 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    step("btb_12", 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    step("btb_13", 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    step("btb_14", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
`endif

    // async reset in the middle of B_YEL with a pending button
    do_reset("rst_t5a");
    for (int k = 1; k <= 16; k++) step($sformatf("mid_%0d", k), 1'b1, 1'b1, 1'b0, reqb_phase(k), 1'b0);
    step("mid_17", 1'b1, 1'b1, 1'b1, 3'd4, 1'b1);
    do_reset("rst_mid_byel");

    // no ticks: state and cnt frozen, button still latches
    for (int k = 1; k <= 50; k++)
      step($sformatf("frz_%0d", k), 1'b0, 1'b1, (k == 10), 3'd0, (k >= 10));
    step("frz_t1", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    step("frz_t2", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    step("frz_t3", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    step("frz_t4", 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
